// File: rtl/multi_cycle_controller_if.sv
// multi_cycle_controller_if: control bus between the multi-cycle controller and its datapath
// Ports (signals):
//   op, func3, func7, zero       - instruction fields and ALU zero flag from the datapath
//   PCSrc, branch, jalr          - PC write enable and PC-update qualifiers
//   MemWrite, RegWrite, IrWrite  - memory / register-file / instruction-register write enables
//   AdrSrc, ResultSrc            - memory address and result mux selects
//   ALUSrcA, ALUSrcB, ImmSrc     - ALU operand and immediate-format selects
//   ALUControl                   - ALU operation
//   state, illegal               - debug state and sticky illegal-instruction flag
// Modports: master = controller, slave = datapath.
interface multi_cycle_controller_if;
   logic [6:0] op;
   logic [2:0] func3;
   logic [6:0] func7;
   logic       zero;
   logic       PCSrc, branch, jalr, MemWrite, RegWrite, AdrSrc, IrWrite;
   logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
   logic [2:0] ImmSrc;
   logic [3:0] ALUControl;
   logic [3:0] state;
   logic       illegal;
   modport master (
      input  op, func3, func7, zero,
      output PCSrc, branch, jalr, MemWrite, RegWrite, AdrSrc, IrWrite,
      output ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, state, illegal
   );
   modport slave (
      output op, func3, func7, zero,
      input  PCSrc, branch, jalr, MemWrite, RegWrite, AdrSrc, IrWrite,
      input  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, state, illegal
   );
endinterface

// File: rtl/multi_cycle_controller.sv
// multi_cycle_controller: FSM control unit for a multi-cycle RV32I-subset datapath
// Ports:
//   CLK   - clock, all state changes on the rising edge
//   rst_n - synchronous active-low reset, forces FETCH and clears illegal
//   m     - multi_cycle_controller_if.master control bus
// Optional feature: define CTRL_BRANCH_EXT_EN to accept bne/blt/bge/bltu/bgeu;
// otherwise only beq is legal and other branch func3 values halt.
module multi_cycle_controller (
   input logic CLK,
   input logic rst_n,
   multi_cycle_controller_if.master m
);
   typedef enum logic [3:0] {
      FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXER, EXEI,
      ALUWB, BRANCH, JAL, JALR1, JALR2, LUI, HALT
   } state_t;
   state_t st, nx, dec_nx;
   logic [3:0] f3_alu, br_alu;
   logic [2:0] imm_dec;
   logic f3_ok, br_ok, br_en;
   always_ff @(posedge CLK) st <= !rst_n ? FETCH : nx;
   assign m.state = st;
   assign m.illegal = st == HALT;
   assign dec_nx = (m.op == 7'b0000011 || m.op == 7'b0100011) ? MEMADR :
                   m.op == 7'b0110011 ? EXER :
                   m.op == 7'b0010011 ? EXEI :
                   m.op == 7'b1100011 ? BRANCH :
                   m.op == 7'b1101111 ? JAL :
                   m.op == 7'b1100111 ? JALR1 :
                   m.op == 7'b0110111 ? LUI : HALT;
   assign imm_dec = m.op == 7'b0100011 ? 3'd1 :
                    m.op == 7'b1100011 ? 3'd2 :
                    m.op == 7'b1101111 ? 3'd3 :
                    m.op == 7'b0110111 ? 3'd4 : 3'd0;
   assign f3_alu = m.func3 == 3'b111 ? 4'd2 :
                   m.func3 == 3'b110 ? 4'd3 :
                   m.func3 == 3'b100 ? 4'd4 :
                   m.func3 == 3'b010 ? 4'd5 :
                   m.func3 == 3'b011 ? 4'd6 : 4'd0;
   assign f3_ok = m.func3 != 3'b001 && m.func3 != 3'b101;
`ifdef CTRL_BRANCH_EXT_EN
   // beq/bne compare by sub, signed/unsigned pairs by slt/sltu; the condition
   // inverts zero for bne/blt/bltu, so branch carries the final taken decision
   assign br_ok = m.func3 != 3'b010 && m.func3 != 3'b011;
   assign br_alu = !m.func3[2] ? 4'd1 : m.func3[1] ? 4'd6 : 4'd5;
   assign br_en = m.zero ^ m.func3[0] ^ m.func3[2];
`else
   // beq only: the datapath qualifies the PC load with zero
   assign br_ok = m.func3 == 3'b000;
   assign br_alu = 4'd1;
   assign br_en = 1'b1;
`endif
   always_comb begin
      nx = st;
      m.PCSrc = 1'b0;
      m.branch = 1'b0;
      m.jalr = 1'b0;
      m.MemWrite = 1'b0;
      m.RegWrite = 1'b0;
      m.AdrSrc = 1'b0;
      m.IrWrite = 1'b0;
      m.ResultSrc = 2'd0;
      m.ALUSrcA = 2'd0;
      m.ALUSrcB = 2'd0;
      m.ImmSrc = 3'd0;
      m.ALUControl = 4'd0;
      case (st)
         FETCH: begin
            m.IrWrite = 1'b1;
            m.ALUSrcB = 2'd2;
            m.ResultSrc = 2'd2;
            m.PCSrc = 1'b1;
            nx = DECODE;
         end
         DECODE: begin
            m.ALUSrcA = 2'd1;
            m.ALUSrcB = 2'd1;
            m.ImmSrc = imm_dec;
            nx = dec_nx;
         end
         MEMADR: begin
            m.ALUSrcA = 2'd2;
            m.ALUSrcB = 2'd1;
            m.ImmSrc = {2'b00, m.op[5]};
            nx = m.op[5] ? MEMWRITE : MEMREAD;
         end
         MEMREAD: begin
            m.AdrSrc = 1'b1;
            nx = MEMWB;
         end
         MEMWB: begin
            m.ResultSrc = 2'd1;
            m.RegWrite = 1'b1;
            nx = FETCH;
         end
         MEMWRITE: begin
            m.AdrSrc = 1'b1;
            m.MemWrite = 1'b1;
            nx = FETCH;
         end
         EXER: begin
            m.ALUSrcA = 2'd2;
            m.ALUControl = (m.func3 == 3'b000 && m.func7 == 7'b0100000) ? 4'd1 : f3_alu;
            nx = f3_ok ? ALUWB : HALT;
         end
         EXEI: begin
            m.ALUSrcA = 2'd2;
            m.ALUSrcB = 2'd1;
            m.ALUControl = f3_alu;
            nx = f3_ok ? ALUWB : HALT;
         end
         ALUWB: begin
            m.RegWrite = 1'b1;
            nx = FETCH;
         end
         BRANCH: begin
            m.ALUSrcA = 2'd2;
            m.ImmSrc = 3'd2;
            m.ALUControl = br_alu;
            m.branch = br_ok & br_en;
            nx = br_ok ? FETCH : HALT;
         end
         JAL: begin
            m.ImmSrc = 3'd3;
            m.ALUSrcA = 2'd1;
            m.ALUSrcB = 2'd2;
            m.PCSrc = 1'b1;
            nx = ALUWB;
         end
         JALR1: begin
            m.ALUSrcA = 2'd2;
            m.ALUSrcB = 2'd1;
            nx = JALR2;
         end
         JALR2: begin
            m.ALUSrcA = 2'd1;
            m.ALUSrcB = 2'd2;
            m.PCSrc = 1'b1;
            m.jalr = 1'b1;
            nx = ALUWB;
         end
         LUI: begin
            m.ImmSrc = 3'd4;
            m.ResultSrc = 2'd3;
            m.RegWrite = 1'b1;
            nx = FETCH;
         end
         default: nx = HALT;
      endcase
      // write enables are suppressed for the whole reset cycle, even mid-instruction
      if (!rst_n) {m.RegWrite, m.MemWrite, m.IrWrite, m.PCSrc} = 4'b0000;
   end
endmodule
